module_calc_ctrl: RTL and testbench
===================================

// Module: module_calc_ctrl
// PURPOSE
//  Sequencer in front of module_BCDBin: assembles two BCD operands from keypad key codes.
//  Drives num1/num2 with listo1/listo2 and waits for listo0 or error from the converter.
//  Then pulses the arithmetic unit's start, waits for its done, and reports busy/done/err.
//  Sits between the keypad decoder and the BCD->binary / ALU datapath.
// PARAMETERS
//  DIGITS       2    BCD digits per operand; operand width = 4*DIGITS
//  TIMEOUT_CYC  1000 watchdog limit in cycles (used only with CALC_CTRL_TIMEOUT_EN)
// PORTS
//  clk        in  1         single system clock, rising edge
//  rst        in  1         synchronous, active-high reset
//  key_valid  in  1         one-cycle pulse: key_code is valid
//  key_code   in  4         0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC-4'hF ignored
//  num1       out 4*DIGITS  BCD operand 1 to converter
//  num2       out 4*DIGITS  BCD operand 2 to converter
//  listo1     out 1         level: operand 1 complete
//  listo2     out 1         level: operand 2 complete
//  conv_done  in  1         converter listo0
//  conv_err   in  1         converter error (invalid BCD)
//  alu_start  out 1         one-cycle start pulse to the ALU
//  alu_done   in  1         ALU result valid
//  busy       out 1         1 in every state except IDLE, DONE and ERROR
//  done       out 1         1 in DONE
//  err        out 1         1 in ERROR
// BEHAVIOUR
//  Reset: state=IDLE. num1=num2=0, listo1=listo2=alu_start=busy=done=err=0, digit counters=0.
//  Digit entry: reg <= {reg[4*DIGITS-5:0], digit}; count++. Digits beyond DIGITS are ignored.
//    Example: keys 4, 2 -> 8'h42.
//  IDLE   : digit -> load it into num1 (count=1), go to ENTER1. ENTER and other keys are ignored.
//  ENTER1 : digit -> shift into num1.
//           ENTER with count>0 -> listo1=1 from the next cycle, go to ENTER2.
//           ENTER with count=0 is ignored.
//  ENTER2 : digit -> shift into num2.
//           ENTER with count>0 -> listo2=1 from the next cycle, go to CONV.
//  CONV   : conv_err -> ERROR. Otherwise conv_done -> ALU.
//           conv_err wins if both are high in the same cycle.
//  ALU    : alu_start=1 only in the first cycle of ALU. alu_done -> DONE.
//           alu_done in the same cycle as alu_start is accepted.
//  DONE   : done=1. listo1/listo2 and the operands are held.
//           A digit clears both operands and listos, loads the digit into num1, goes to ENTER1.
//  ERROR  : err=1. Only CLEAR leaves this state.
//  CLEAR in any state -> IDLE next cycle with reset values.
//    CLEAR has priority over every simultaneous event (digit, conv_*, alu_done).
//  listo1/listo2 stay high until CLEAR or a new operation. They never drop during CONV or ALU.
//  key_valid pulses are ignored in CONV and ALU, except CLEAR.
//  conv_done, conv_err and alu_done are ignored outside CONV and ALU respectively.
//  rst mid-operation: next cycle equals the reset state. alu_start is not re-pulsed.
// CONFIGURATION
//  `CALC_CTRL_TIMEOUT_EN defined:
//    A counter is cleared on entry to CONV and on entry to ALU, and increments while in either.
//    Reaching TIMEOUT_CYC without the awaited response -> ERROR.
//  Not defined: no counter is built; CONV and ALU wait indefinitely.
// STRUCTURE
//  calc_pkg:
//    typedef enum logic [2:0] {IDLE, ENTER1, ENTER2, CONV, ALU, DONE, ERROR} calc_state_t
//    localparam KEY_ENTER=4'hA, KEY_CLEAR=4'hB
//    function is_digit(code)
//  Sub-module module_bcd_shreg (DIGITS param; clr, shift_en, digit in; value, count out).
//    Instantiated twice, for num1 and num2.
//  Top: FSM, listo flags, start pulse, optional watchdog.
// TESTING
//  1 Keys 4,2,ENTER,1,9,ENTER; conv_done 3 cycles later
//    -> num1=8'h42, num2=8'h19, listo1 then listo2 high, one alu_start pulse;
//    alu_done -> done=1, busy=0.
//  2 Keys 1,2,3,ENTER
//    -> num1=8'h12 (third digit dropped). ENTER pressed before any digit -> state unchanged.
//  3 In CONV, conv_err and conv_done high together
//    -> err=1, no alu_start. CLEAR -> IDLE, all outputs at reset values.
//  4 CLEAR in the same cycle as alu_done -> IDLE, done stays 0.
//    rst mid-ENTER2 -> num2=0, listo1=0.
//  5 From DONE, key 7 -> num1=8'h07, num2=0, listo1=listo2=0, state ENTER1.
//  6 With CALC_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16: no conv_done -> err=1 after 16 cycles in CONV.
//    Without the macro: still busy after 100 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, key codes and key classification for the calculator sequencer
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTER1,
    ENTER2,
    CONV,
    ALU,
    DONE,
    ERROR
  } calc_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  // Key codes 0-9 are decimal digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/module_bcd_shreg.sv
// rtl/module_bcd_shreg.sv - BCD operand shift register with digit counter and overflow drop
module module_bcd_shreg
  import calc_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       shift_en_i,
  input  logic [3:0]                 digit_i,
  output logic [4*DIGITS-1:0]        value_o,
  output logic [$clog2(DIGITS+1)-1:0] count_o
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [VW-1:0] value_q, value_d;
  logic [CW-1:0] count_q, count_d;

  // Clear first, then shift: clr_i together with shift_en_i loads a fresh first digit.
  always_comb begin
    value_d = clr_i ? '0 : value_q;
    count_d = clr_i ? '0 : count_q;
    if (shift_en_i && (count_d < CW'(DIGITS))) begin
      value_d = VW'({value_d, digit_i});
      count_d = count_d + CW'(1);
    end
  end

  // Operand and digit count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;
  assign count_o = count_q;

endmodule

// File: rtl/module_calc_ctrl.sv
// rtl/module_calc_ctrl.sv - keypad-to-converter/ALU sequencer; optional watchdog via CALC_CTRL_TIMEOUT_EN
module module_calc_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] num1,
  output logic [4*DIGITS-1:0] num2,
  output logic                listo1,
  output logic                listo2,
  input  logic                conv_done,
  input  logic                conv_err,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = $clog2(DIGITS + 1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  calc_state_t state_q, state_d;
  logic        listo1_q, listo1_d;
  logic        listo2_q, listo2_d;
  logic        alu_start_q;
  logic        sh1_clr, sh1_shift, sh2_clr, sh2_shift;
  logic [CW-1:0] cnt1, cnt2;
  logic        timeout_hit;

  wire key_is_digit = key_valid && is_digit(key_code);
  wire key_enter    = key_valid && (key_code == KEY_ENTER);
  wire key_clear    = key_valid && (key_code == KEY_CLEAR);

  module_bcd_shreg #(.DIGITS(DIGITS)) u_op1 (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (sh1_clr),
    .shift_en_i(sh1_shift),
    .digit_i   (key_code),
    .value_o   (num1),
    .count_o   (cnt1)
  );

  module_bcd_shreg #(.DIGITS(DIGITS)) u_op2 (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (sh2_clr),
    .shift_en_i(sh2_shift),
    .digit_i   (key_code),
    .value_o   (num2),
    .count_o   (cnt2)
  );

`ifdef CALC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  // Watchdog restarts on every state change and counts while waiting in CONV or ALU.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q) || !(state_q inside {CONV, ALU})) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign timeout_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state, operand register controls and listo flags; CLEAR overrides everything.
  always_comb begin
    state_d   = state_q;
    listo1_d  = listo1_q;
    listo2_d  = listo2_q;
    sh1_clr   = 1'b0;
    sh1_shift = 1'b0;
    sh2_clr   = 1'b0;
    sh2_shift = 1'b0;
    if (key_clear) begin
      state_d  = IDLE;
      listo1_d = 1'b0;
      listo2_d = 1'b0;
      sh1_clr  = 1'b1;
      sh2_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_is_digit) begin
            sh1_clr   = 1'b1;
            sh1_shift = 1'b1;
            state_d   = ENTER1;
          end
        end
        ENTER1: begin
          if (key_is_digit) begin
            sh1_shift = 1'b1;
          end else if (key_enter && (cnt1 != '0)) begin
            listo1_d = 1'b1;
            state_d  = ENTER2;
          end
        end
        ENTER2: begin
          if (key_is_digit) begin
            sh2_shift = 1'b1;
          end else if (key_enter && (cnt2 != '0)) begin
            listo2_d = 1'b1;
            state_d  = CONV;
          end
        end
        CONV: begin
          if (conv_err)         state_d = ERROR;
          else if (conv_done)   state_d = ALU;
          else if (timeout_hit) state_d = ERROR;
        end
        ALU: begin
          if (alu_done)         state_d = DONE;
          else if (timeout_hit) state_d = ERROR;
        end
        DONE: begin
          if (key_is_digit) begin
            listo1_d  = 1'b0;
            listo2_d  = 1'b0;
            sh1_clr   = 1'b1;
            sh1_shift = 1'b1;
            sh2_clr   = 1'b1;
            state_d   = ENTER1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, listo flags and a start pulse raised only on the cycle ALU is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      listo1_q    <= 1'b0;
      listo2_q    <= 1'b0;
      alu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      listo1_q    <= listo1_d;
      listo2_q    <= listo2_d;
      alu_start_q <= (state_d == ALU) && (state_q != ALU);
    end
  end

  assign listo1    = listo1_q;
  assign listo2    = listo2_q;
  assign alu_start = alu_start_q;
  assign busy      = state_q inside {ENTER1, ENTER2, CONV, ALU};
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERROR);

endmodule

// File: tb/tb_module_calc_ctrl.sv
// tb/tb_module_calc_ctrl.sv - self-checking bench for module_calc_ctrl with a phase/queue reference model
module tb_module_calc_ctrl;

  localparam int DIGITS = 2;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       conv_done, conv_err, alu_done;
  logic [7:0] num1, num2;
  logic       listo1, listo2, alu_start, busy, done, err;

  int checks   = 0;
  int failures = 0;

  module_calc_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .num1     (num1),
    .num2     (num2),
    .listo1   (listo1),
    .listo2   (listo2),
    .conv_done(conv_done),
    .conv_err (conv_err),
    .alu_start(alu_start),
    .alu_done (alu_done),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 first operand, 2 second operand,
  // 3 waiting converter, 4 waiting ALU, 5 finished, 6 error.
  int  ph;
  int  q1[$];
  int  q2[$];
  bit  l1, l2, exp_start, armed;
  int  waitc;
  int  starts;

  function automatic logic [31:0] bcd_of(input int q[$]);
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic model_reset();
    ph = 0; q1.delete(); q2.delete(); l1 = 0; l2 = 0; waitc = 0;
  endtask

  always @(posedge clk) begin
    bit dig, ent;
    dig = key_valid && (key_code <= 4'd9);
    ent = key_valid && (key_code == 4'hA);
    exp_start = 0;
    if (rst) begin
      model_reset();
      armed = 1;
    end else if (key_valid && key_code == 4'hB) begin
      model_reset();
    end else begin
      case (ph)
        0: if (dig) begin q1 = {int'(key_code)}; ph = 1; end
        1: begin
          if (dig) begin
            if (q1.size() < DIGITS) q1.push_back(int'(key_code));
          end else if (ent && q1.size() > 0) begin
            l1 = 1; ph = 2;
          end
        end
        2: begin
          if (dig) begin
            if (q2.size() < DIGITS) q2.push_back(int'(key_code));
          end else if (ent && q2.size() > 0) begin
            l2 = 1; ph = 3; waitc = 0;
          end
        end
        3: begin
          if (conv_err) ph = 6;
          else if (conv_done) begin ph = 4; exp_start = 1; waitc = 0; end
`ifdef CALC_CTRL_TIMEOUT_EN
          else begin waitc++; if (waitc == TMO) ph = 6; end
`endif
        end
        4: begin
          if (alu_done) ph = 5;
`ifdef CALC_CTRL_TIMEOUT_EN
          else begin waitc++; if (waitc == TMO) ph = 6; end
`endif
        end
        5: if (dig) begin
          q1 = {int'(key_code)}; q2.delete(); l1 = 0; l2 = 0; ph = 1;
        end
        default: ;
      endcase
    end
    #1;
    if (armed) begin
      chk("num1", num1, bcd_of(q1));
      chk("num2", num2, bcd_of(q2));
      chk("listo1", listo1, l1);
      chk("listo2", listo2, l2);
      chk("alu_start", alu_start, exp_start);
      chk("busy", busy, (ph >= 1 && ph <= 4));
      chk("done", done, ph == 5);
      chk("err", err, ph == 6);
      if (alu_start === 1'b1) starts++;
    end
  end

  task automatic drv(input logic kv, input logic [3:0] kc, input logic cd, input logic ce, input logic ad);
    @(negedge clk);
    key_valid = kv; key_code = kc; conv_done = cd; conv_err = ce; alu_done = ad;
  endtask

  task automatic key(input logic [3:0] kc);
    drv(1'b1, kc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    armed = 0; starts = 0;
    model_reset();
    rst = 1'b1; key_valid = 0; key_code = 0; conv_done = 0; conv_err = 0; alu_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_num1", num1, 32'h0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_listo1", listo1, 32'h0);

    // Full operation 42 / 19
    key(4'h4); key(4'h2); key(4'hA); key(4'h1); key(4'h9); key(4'hA);
    idle(3);
    drv(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(2);
    drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t1_num1", num1, 32'h42);
    chk("t1_num2", num2, 32'h19);
    chk("t1_listo", {listo2, listo1}, 32'h3);
    chk("t1_done", done, 32'h1);
    chk("t1_busy", busy, 32'h0);
    chk("t1_starts", starts, 32'd1);

    // Third digit dropped, ENTER with no digits ignored
    key(4'hB); key(4'hA); idle(1);
    chk("t2_idle_enter", busy, 32'h0);
    key(4'h1); key(4'h2); key(4'h3); key(4'hA); idle(1);
    chk("t2_num1", num1, 32'h12);
    chk("t2_listo1", listo1, 32'h1);
    key(4'hA); idle(1);
    chk("t2_empty_enter", listo2, 32'h0);
    chk("t2_busy", busy, 32'h1);
    key(4'h5); key(4'hA); idle(1);
    chk("t2_listo2", listo2, 32'h1);

    // conv_err and conv_done together
    drv(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("t3_err", err, 32'h1);
    chk("t3_starts", starts, 32'd1);
    key(4'hB); idle(1);
    chk("t3_clear", {err, done, busy, listo2, listo1, num2, num1}, 32'h0);

    // CLEAR with alu_done, then reset mid-ENTER2
    key(4'h1); key(4'hA); key(4'h2); key(4'hA); idle(1);
    drv(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t4_done", done, 32'h0);
    chk("t4_busy", busy, 32'h0);
    chk("t4_starts", starts, 32'd2);
    key(4'h3); key(4'hA); key(4'h4); idle(1);
    chk("t4_num2", num2, 32'h4);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("t4_rst_num2", num2, 32'h0);
    chk("t4_rst_listo1", listo1, 32'h0);

    // alu_done on the start cycle, then a new digit from DONE
    key(4'h2); key(4'hA); key(4'h3); key(4'hA); idle(1);
    drv(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t5_done", done, 32'h1);
    key(4'h7); idle(1);
    chk("t5_num1", num1, 32'h07);
    chk("t5_num2", num2, 32'h0);
    chk("t5_listo", {listo2, listo1}, 32'h0);
    chk("t5_busy", busy, 32'h1);

    // Converter never answers
    key(4'hA); key(4'h8); key(4'hA);
`ifdef CALC_CTRL_TIMEOUT_EN
    idle(16);
    chk("t6_before_tmo", err, 32'h0);
    idle(1);
    chk("t6_tmo_err", err, 32'h1);
`else
    idle(100);
    chk("t6_still_busy", busy, 32'h1);
    chk("t6_no_err", err, 32'h0);
`endif
    key(4'hB); idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
